// File: rtl/rb_frame_controller_pkg.sv
// Shared constants and strobe tag type for the row-buffer frame controller.
package rb_frame_controller_pkg;

  localparam int RBs      = 4;
  localparam int RB_DEPTH = 512;

  typedef struct packed {
    logic wr;
    logic rd;
  } rb_strb_t;

  // Counter width that never collapses to zero bits for degenerate sizes.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rb_frame_controller_if.sv
// Start/stall request and strobe/window outputs of the frame controller.
interface rb_frame_controller_if import rb_frame_controller_pkg::*; #(
  parameter int IMG_W = RB_DEPTH,
  parameter int IMG_H = 512
) ();
  logic                   start;
  logic                   stall;
  logic                   en_e_mem_addr;
  logic                   en_w_bram_addr;
  logic                   en_r_bram_addr;
  logic                   window_valid;
  logic [cw(IMG_H)-1:0]   win_row;
  logic [cw(IMG_W)-1:0]   win_col;
  logic                   busy;
  logic                   done;

  modport master (
    input  start, stall,
    output en_e_mem_addr, en_w_bram_addr, en_r_bram_addr,
           window_valid, win_row, win_col, busy, done
  );

  modport slave (
    output start, stall,
    input  en_e_mem_addr, en_w_bram_addr, en_r_bram_addr,
           window_valid, win_row, win_col, busy, done
  );
endinterface

// File: rtl/rb_frame_controller_delay_pipe.sv
// Free-running tag delay line; din is {wr, rd, pos}, taps expose strobes at TAP
// and {rd, pos} at the last stage.
module rb_delay_pipe #(
  parameter int DEPTH = 4,
  parameter int TAP   = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [1:0]   tap_wr,
  output logic [W-2:0] tap_win
);
  logic [DEPTH:1][W-1:0] stg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stg <= '0;
    end else begin
      stg[1] <= din;
      for (int i = 2; i <= DEPTH; i++) stg[i] <= stg[i-1];
    end
  end

  assign tap_wr  = stg[TAP][W-1 -: 2];
  assign tap_win = stg[DEPTH][W-2:0];
endmodule

// File: rtl/rb_frame_controller.sv
// Raster-order fetch sequencer: PRIME fills the row buffers, STREAM fetches with
// coincident BRAM read/write, WAIT drains the delay pipe before DONE.
module rb_frame_controller import rb_frame_controller_pkg::*; #(
  parameter int IMG_W  = RB_DEPTH,
  parameter int IMG_H  = 512,
  parameter int RBS    = RBs,
  parameter int WR_DLY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  rb_frame_controller_if.master bus
);
  localparam int CW = cw(IMG_W);
  localparam int RW = cw(IMG_H);
  localparam int WW = cw(WR_DLY + 2);
  localparam int TW = 2 + RW + CW;

  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
  localparam logic [RW-1:0] PRIME_LAST = RW'(RBS - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(WR_DLY + 1);

  typedef enum logic [2:0] {IDLE, PRIME, STREAM, WAIT, DONE} state_t;

  typedef struct packed {
    rb_strb_t        s;
    logic [RW-1:0]   row;
    logic [CW-1:0]   col;
  } tag_t;

  typedef struct packed {
    logic            rd;
    logic [RW-1:0]   row;
    logic [CW-1:0]   col;
  } win_t;

  state_t        state, state_nxt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [WW-1:0] wcnt;
  logic          fetch, busy, done;
  logic          row_end, prime_end, frame_end;
  tag_t          tag_in;
  rb_strb_t      tag_wr;
  win_t          tag_win;

  assign row_end   = (col == COL_LAST);
  assign prime_end = fetch && row_end && (row == PRIME_LAST);
  assign frame_end = fetch && row_end && (row == ROW_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fetch     = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (bus.start) state_nxt = PRIME;
      end
      PRIME: begin
        fetch = !bus.stall;
        // With no rows left to stream, the prime pass already ends the frame.
        if (prime_end) state_nxt = (IMG_H == RBS) ? WAIT : STREAM;
      end
      STREAM: begin
        fetch = !bus.stall;
        if (frame_end) state_nxt = WAIT;
      end
      WAIT:    if (wcnt == WAIT_LAST) state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col  <= '0;
      row  <= '0;
      wcnt <= '0;
    end else begin
      if (fetch) begin
        if (row_end) begin
          col <= '0;
          row <= frame_end ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      wcnt <= (state == WAIT) ? wcnt + 1'b1 : '0;
    end
  end

  always_comb begin
    tag_in = '0;
    if (fetch) begin
      tag_in.s.wr = 1'b1;
      tag_in.s.rd = (state == STREAM);
      tag_in.row  = row;
      tag_in.col  = col;
    end
  end

  // Pipe keeps shifting under stall so in-flight writes still land on time.
  rb_delay_pipe #(
    .DEPTH (WR_DLY + 2),
    .TAP   (WR_DLY),
    .W     (TW)
  ) u_pipe (
    .clk     (clk),
    .rst     (rst),
    .din     (tag_in),
    .tap_wr  (tag_wr),
    .tap_win (tag_win)
  );

  assign bus.en_e_mem_addr  = fetch;
  assign bus.en_w_bram_addr = tag_wr.wr;
  assign bus.en_r_bram_addr = tag_wr.rd;
  assign bus.window_valid   = tag_win.rd;
  assign bus.win_row        = tag_win.row;
  assign bus.win_col        = tag_win.col;
  assign bus.busy           = busy;
  assign bus.done           = done;
endmodule

// File: tb/tb_rb_frame_controller.sv
// Drives two controllers (4x3/RBS 2 and 4x2/RBS 2) with shared stimulus and
// compares every cycle against a frame-level schedule built from pixel timing.
module tb_rb_frame_controller;
  import rb_frame_controller_pkg::*;

  localparam int W = 4;
  localparam int D = 2;
  localparam int L = 80;

  logic clk = 1'b0;
  logic rst, start, stall;
  always #5 clk = ~clk;

  rb_frame_controller_if #(.IMG_W(W), .IMG_H(3)) ifa ();
  rb_frame_controller_if #(.IMG_W(W), .IMG_H(2)) ifb ();

  assign ifa.start = start;
  assign ifa.stall = stall;
  assign ifb.start = start;
  assign ifb.stall = stall;

  rb_frame_controller #(.IMG_W(W), .IMG_H(3), .RBS(2), .WR_DLY(D)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa));
  rb_frame_controller #(.IMG_W(W), .IMG_H(2), .RBS(2), .WR_DLY(D)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb));

  int total = 0, passes = 0, fails = 0;

  // Stimulus per cycle and expected {fetch, wr, rd, wv, busy, done} per DUT.
  bit       st [L];
  bit       sl [L];
  bit       rs [L];
  logic [5:0] ev [2][L];
  int       er [2][L];
  int       ec [2][L];

  task automatic chk(input string nm, input int c, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s cycle %0d: got %0h expected %0h", nm, c, obs, exp);
    end
  endtask

  task automatic mark(input int k, input int c, input int b);
    if (c < L) ev[k][c][b] = 1'b1;
  endtask

  // Frame-level model: each accepted start fetches W*H pixels on unstalled
  // cycles; write lands D later, window D+2 later, done at last fetch + D + 3.
  task automatic build(input int k, input int H, input int R);
    int free, f, p, dn;
    free = 0;
    for (int c = 0; c < L; c++) begin
      ev[k][c] = '0; er[k][c] = 0; ec[k][c] = 0;
    end
    for (int c = 0; c < L; c++) begin
      if (rs[c]) begin
        for (int j = c + 1; j < L; j++) ev[k][j] = '0;
        free = c + 1;
      end else if (c >= free && st[c]) begin
        p = 0;
        f = c;
        while (p < W * H && f < L) begin
          f++;
          if (f < L && !sl[f]) begin
            mark(k, f, 5);
            mark(k, f + D, 4);
            if (p / W >= R) begin
              mark(k, f + D, 3);
              mark(k, f + D + 2, 2);
              if (f + D + 2 < L) begin
                er[k][f+D+2] = p / W;
                ec[k][f+D+2] = p % W;
              end
            end
            p++;
          end
        end
        dn = f + D + 3;
        for (int j = c + 1; j <= dn; j++) mark(k, j, 1);
        mark(k, dn, 0);
        free = dn + 1;
      end
    end
  endtask

  task automatic clr();
    for (int c = 0; c < L; c++) begin
      st[c] = 1'b0; sl[c] = 1'b0; rs[c] = 1'b0;
    end
  endtask

  task automatic run(input string tag);
    logic [5:0] oa, ob;
    build(0, 3, 2);
    build(1, 2, 2);
    rst = 1'b1; start = 1'b0; stall = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < L; c++) begin
      rst = rs[c]; start = st[c]; stall = sl[c];
      @(negedge clk);
      oa = {ifa.en_e_mem_addr, ifa.en_w_bram_addr, ifa.en_r_bram_addr,
            ifa.window_valid, ifa.busy, ifa.done};
      ob = {ifb.en_e_mem_addr, ifb.en_w_bram_addr, ifb.en_r_bram_addr,
            ifb.window_valid, ifb.busy, ifb.done};
      chk({tag, "/A strobes"}, c, 32'(oa), 32'(ev[0][c]));
      chk({tag, "/B strobes"}, c, 32'(ob), 32'(ev[1][c]));
      if (ev[0][c][2]) begin
        chk({tag, "/A win_row"}, c, 32'(ifa.win_row), er[0][c]);
        chk({tag, "/A win_col"}, c, 32'(ifa.win_col), ec[0][c]);
      end
      if (ev[1][c][2]) begin
        chk({tag, "/B win_row"}, c, 32'(ifb.win_row), er[1][c]);
        chk({tag, "/B win_col"}, c, 32'(ifb.win_col), ec[1][c]);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0; start = 1'b0; stall = 1'b0;
  endtask

  initial begin
    int r0;
    rst = 1'b1; start = 1'b0; stall = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset A", 0, {ifa.en_e_mem_addr, ifa.en_w_bram_addr, ifa.en_r_bram_addr,
        ifa.window_valid, ifa.busy, ifa.done, ifa.win_row, ifa.win_col}, 0);
    chk("reset B", 0, {ifb.en_e_mem_addr, ifb.en_w_bram_addr, ifb.en_r_bram_addr,
        ifb.window_valid, ifb.busy, ifb.done, ifb.win_row, ifb.win_col}, 0);
    @(posedge clk); #1;

    clr(); st[0] = 1'b1;
    run("basic");

    clr(); st[0] = 1'b1; sl[5] = 1'b1; sl[6] = 1'b1;
    run("stall");

    clr(); st[0] = 1'b1; sl[12] = 1'b1; sl[13] = 1'b1;
    run("last_stall");

    clr(); st[0] = 1'b1; rs[6] = 1'b1; st[9] = 1'b1;
    run("mid_reset");

    clr(); for (int c = 0; c <= 20; c++) st[c] = 1'b1;
    run("held_start");

    for (int n = 0; n < 6; n++) begin
      clr();
      st[$urandom_range(0, 4)] = 1'b1;
      for (int c = 0; c < 30; c++) begin
        if ($urandom_range(0, 15) == 0) st[c] = 1'b1;
        sl[c] = ($urandom_range(0, 3) == 0);
      end
      for (int c = 30; c < 50; c++) sl[c] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) begin
        r0 = $urandom_range(3, 25);
        rs[r0] = 1'b1;
      end
      run($sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
